// File: rtl/branch_ctrl.sv
// Branch-resolution and run-control unit: decodes the current instruction for the fetcher,
// owns the GE compare flag, and runs the Start/Done handshake with HALT and cycle-limit stop.
module branch_ctrl #(
    parameter int unsigned IW         = 9,
    parameter int unsigned DW         = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 40000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [IW-1:0]    Instr,
    input  logic [DW-1:0]    CmpA,
    input  logic [DW-1:0]    CmpB,
    output logic             BranchEn,
    output logic             ConditionBranch,
    output logic             GE_Flag,
    output logic [4:0]       BranchOffset,
    output logic             Done,
    output logic             TimedOut,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0]       OP_CMP   = 4'b1100;
    localparam logic [3:0]       OP_BR    = 4'b1101;
    localparam logic [3:0]       OP_BGE   = 4'b1110;
    localparam logic [3:0]       OP_HALT  = 4'b1111;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

    state_t           state, nextState;
    logic             geNext, doneNext, timedOutNext;
    logic [CNT_W-1:0] countNext;
    logic [3:0]       opcode;
    logic [4:0]       offset;
    logic             active;

    assign opcode = Instr[IW-1:IW-4];
    assign offset = Instr[4:0];
    // Reset is gated in so the fetcher sees no branch while the synchronous reset is pending.
    assign active = !Reset && !Start && (state != DONE);

    always_comb begin
        nextState       = state;
        geNext          = GE_Flag;
        doneNext        = Done;
        timedOutNext    = TimedOut;
        countNext       = CycleCount;
        BranchEn        = 1'b0;
        ConditionBranch = 1'b0;
        BranchOffset    = '0;

        if (Start) begin
            nextState    = IDLE;
            geNext       = 1'b0;
            doneNext     = 1'b0;
            timedOutNext = 1'b0;
            countNext    = '0;
        end else if (active) begin
            nextState = RUN;
            countNext = CycleCount + CNT_W'(1);
            if (opcode == OP_CMP)
                geNext = (CmpA >= CmpB);
            if (opcode == OP_BR || opcode == OP_BGE) begin
                BranchEn        = 1'b1;
                ConditionBranch = (opcode == OP_BGE);
                BranchOffset    = offset;
            end
            // HALT takes precedence over the cycle limit when both land together.
            if (opcode == OP_HALT && offset == 5'h1F) begin
                nextState    = DONE;
                doneNext     = 1'b1;
                timedOutNext = 1'b0;
            end else if (CycleCount == LAST_CNT) begin
                nextState    = DONE;
                doneNext     = 1'b1;
                timedOutNext = 1'b1;
            end
        end else if (state == DONE && !Reset) begin
            BranchEn = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            GE_Flag    <= 1'b0;
            Done       <= 1'b0;
            TimedOut   <= 1'b0;
            CycleCount <= '0;
        end else begin
            state      <= nextState;
            GE_Flag    <= geNext;
            Done       <= doneNext;
            TimedOut   <= timedOutNext;
            CycleCount <= countNext;
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a tiny ROM plus fetcher model closes the PC loop around the DUT.
module tb_branch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [8:0]  Instr;
    logic [7:0]  CmpA, CmpB;
    logic        BranchEn, ConditionBranch, GE_Flag, Done, TimedOut;
    logic [4:0]  BranchOffset;
    logic [15:0] CycleCount;

    logic [8:0]  rom [0:255];
    logic [7:0]  pc;
    int unsigned checks = 0;
    int unsigned failures = 0;

    localparam logic [8:0] I_NOP  = 9'h000;
    localparam logic [8:0] I_CMP  = 9'h180;
    localparam logic [8:0] I_BGE  = 9'h1DD;
    localparam logic [8:0] I_BR0  = 9'h1A0;
    localparam logic [8:0] I_HALT = 9'h1FF;

    branch_ctrl #(.IW(9), .DW(8), .CNT_W(16), .MAX_CYCLES(20)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .CmpA(CmpA), .CmpB(CmpB),
        .BranchEn(BranchEn), .ConditionBranch(ConditionBranch), .GE_Flag(GE_Flag),
        .BranchOffset(BranchOffset), .Done(Done), .TimedOut(TimedOut), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    assign Instr = rom[pc];

    // Fetcher: PC held at 0 during Start/Reset, otherwise +1 or +signed offset when taken.
    always_ff @(posedge Clk) begin
        if (Reset || Start)
            pc <= 8'd0;
        else if (BranchEn && (!ConditionBranch || GE_Flag))
            pc <= pc + {{3{BranchOffset[4]}}, BranchOffset};
        else
            pc <= pc + 8'd1;
    end

    task automatic loadRom(input logic [8:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    task automatic runStart();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; CmpA = '0; CmpB = '0;
        loadRom(I_NOP);
        repeat (2) @(negedge Clk);
        checks++; if (CycleCount !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", CycleCount); end
        checks++; if ({Done, TimedOut, GE_Flag, BranchEn} !== 4'b0000) begin failures++;
            $display("FAIL reset_flags got=%b exp=0000", {Done, TimedOut, GE_Flag, BranchEn}); end
        Reset = 1'b0;
    endtask

    task automatic test_nonbranch();
        loadRom(I_NOP);
        runStart();
        for (int i = 0; i < 3; i++) begin
            checks++; if (BranchEn !== 1'b0) begin failures++; $display("FAIL nop_branchen cyc=%0d got=%b exp=0", i + 1, BranchEn); end
            @(negedge Clk);
            checks++; if (CycleCount !== 16'(i + 1)) begin failures++; $display("FAIL nop_count got=%0d exp=%0d", CycleCount, i + 1); end
        end
    endtask

    task automatic test_bge_taken();
        loadRom(I_NOP); rom[0] = I_CMP; rom[1] = I_BGE;
        CmpA = 8'd5; CmpB = 8'd5;
        runStart();
        checks++; if (BranchEn !== 1'b0) begin failures++; $display("FAIL cmp_branchen got=%b exp=0", BranchEn); end
        @(negedge Clk);
        checks++; if (GE_Flag !== 1'b1) begin failures++; $display("FAIL ge_eq got=%b exp=1", GE_Flag); end
        checks++; if ({BranchEn, ConditionBranch, BranchOffset} !== {2'b11, 5'h1D}) begin failures++;
            $display("FAIL bge_outputs got=%b%b_%h exp=11_1d", BranchEn, ConditionBranch, BranchOffset); end
        @(negedge Clk);
        checks++; if (pc !== 8'd254) begin failures++; $display("FAIL bge_taken_pc got=%0d exp=254", pc); end
    endtask

    task automatic test_bge_not_taken();
        loadRom(I_NOP); rom[0] = I_CMP; rom[1] = I_BGE;
        CmpA = 8'd3; CmpB = 8'd200;
        runStart();
        checks++; if (GE_Flag !== 1'b0) begin failures++; $display("FAIL start_clears_ge got=%b exp=0", GE_Flag); end
        @(negedge Clk);
        checks++; if ({GE_Flag, BranchEn, ConditionBranch} !== 3'b011) begin failures++;
            $display("FAIL ge_lt got=%b exp=011", {GE_Flag, BranchEn, ConditionBranch}); end
        @(negedge Clk);
        checks++; if (pc !== 8'd2) begin failures++; $display("FAIL bge_not_taken_pc got=%0d exp=2", pc); end
    endtask

    task automatic test_halt();
        loadRom(I_NOP); rom[6] = I_HALT;
        runStart();
        repeat (6) @(negedge Clk);
        checks++; if ({BranchEn, Done} !== 2'b00) begin failures++; $display("FAIL halt_cycle got=%b exp=00", {BranchEn, Done}); end
        @(negedge Clk);
        checks++; if ({Done, TimedOut} !== 2'b10) begin failures++; $display("FAIL halt_done got=%b exp=10", {Done, TimedOut}); end
        checks++; if (CycleCount !== 16'd7) begin failures++; $display("FAIL halt_count got=%0d exp=7", CycleCount); end
        for (int i = 0; i < 10; i++) begin
            checks++; if ({BranchEn, ConditionBranch, BranchOffset, pc} !== {2'b10, 5'h00, 8'd7}) begin failures++;
                $display("FAIL halt_freeze cyc=%0d got=%b%b_%h pc=%0d exp=10_00 pc=7", i, BranchEn, ConditionBranch, BranchOffset, pc); end
            @(negedge Clk);
        end
        checks++; if (CycleCount !== 16'd7) begin failures++; $display("FAIL halt_count_frozen got=%0d exp=7", CycleCount); end
    endtask

    task automatic test_timeout();
        int unsigned waited;
        loadRom(I_NOP); rom[0] = I_CMP; rom[1] = I_BR0;
        CmpA = 8'd9; CmpB = 8'd1;
        runStart();
        waited = 0;
        while (Done !== 1'b1 && waited < 40) begin
            @(negedge Clk);
            waited++;
        end
        checks++; if (Done !== 1'b1) begin failures++; $display("FAIL timeout_wait got Done=%b exp=1 within 40 cycles", Done); end
        checks++; if ({TimedOut, GE_Flag, CycleCount} !== {2'b11, 16'd20}) begin failures++;
            $display("FAIL timeout_state got to=%b ge=%b cnt=%0d exp to=1 ge=1 cnt=20", TimedOut, GE_Flag, CycleCount); end
        Start = 1'b1;
        @(negedge Clk);
        checks++; if ({Done, TimedOut, GE_Flag, CycleCount} !== {3'b000, 16'd0}) begin failures++;
            $display("FAIL restart_clear got d=%b to=%b ge=%b cnt=%0d exp all 0", Done, TimedOut, GE_Flag, CycleCount); end
    endtask

    task automatic test_halt_at_limit();
        loadRom(I_NOP); rom[19] = I_HALT;
        runStart();
        repeat (20) @(negedge Clk);
        checks++; if ({Done, TimedOut, CycleCount} !== {2'b10, 16'd20}) begin failures++;
            $display("FAIL halt_vs_timeout got d=%b to=%b cnt=%0d exp d=1 to=0 cnt=20", Done, TimedOut, CycleCount); end
    endtask

    task automatic test_reset_midrun();
        loadRom(I_NOP); rom[0] = I_CMP; rom[3] = I_BGE;
        CmpA = 8'd200; CmpB = 8'd3;
        runStart();
        repeat (3) @(negedge Clk);
        checks++; if ({GE_Flag, BranchEn} !== 2'b11) begin failures++; $display("FAIL pre_reset got=%b exp=11", {GE_Flag, BranchEn}); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if ({GE_Flag, Done, TimedOut, BranchEn, ConditionBranch, BranchOffset, CycleCount} !== '0) begin failures++;
            $display("FAIL midrun_reset got ge=%b d=%b to=%b be=%b cb=%b off=%h cnt=%0d exp all 0",
                GE_Flag, Done, TimedOut, BranchEn, ConditionBranch, BranchOffset, CycleCount); end
        Start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nonbranch();
        test_bge_taken();
        test_bge_not_taken();
        test_halt();
        test_timeout();
        test_halt_at_limit();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
